// File: rtl/dataplane_pkg.sv
// Shared types and constants for the ingress dataplane blocks.
package dataplane_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int   CNT_W     = 32;
    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Packet counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rx_port_arbiter_rr.sv
// Combinational masked priority encoder: round-robin from rr_ptr, or fixed
// lowest-index-first. Reusable by the egress schedulers.
module rr_arbiter
    import dataplane_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    input  logic                 arb_mode,
    output logic [IDX_W-1:0]     winner,
    output logic                 any_req
);

    // Scan requests starting at the base index, wrapping once around the ports.
    always_comb begin
        int base_s;
        int idx_s;
        winner  = '0;
        any_req = 1'b0;
        base_s  = (arb_mode == ARB_FIXED) ? 0 : int'(rr_ptr);
        idx_s   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_s = (base_s + k >= NUM_PORTS) ? base_s + k - NUM_PORTS : base_s + k;
            if (!any_req && req[idx_s]) begin
                winner  = IDX_W'(idx_s);
                any_req = 1'b1;
            end else begin
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/rx_port_arbiter.sv
// Packet-granular arbiter sharing the axi_rx ingress pipeline between
// NUM_PORTS AXI-Stream sources; grant is held from first beat through tlast.
module rx_port_arbiter
    import dataplane_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_PORTS  = 4,
    localparam int IDX_W      = $clog2(NUM_PORTS),
    localparam int KEEP_W     = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          s_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0]   s_tkeep,
    input  logic [NUM_PORTS-1:0]          s_tlast,
    output logic [NUM_PORTS-1:0]          s_tready,
    output logic                          m_tvalid,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [KEEP_W-1:0]             m_tkeep,
    output logic                          m_tlast,
    input  logic                          m_tready,
    input  logic [NUM_PORTS-1:0]          port_en,
    input  logic                          arb_mode,
    input  logic                          cnt_clr,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_id,
    output logic [NUM_PORTS*CNT_W-1:0]    pkt_cnt
);

    arb_state_t                 state_r;
    arb_state_t                 next_state_s;
    logic [IDX_W-1:0]           grant_id_r;
    logic [IDX_W-1:0]           rr_ptr_r;
    logic [IDX_W-1:0]           winner_s;
    logic [IDX_W-1:0]           next_ptr_s;
    logic                       grant_valid_r;
    logic                       mode_r;
    logic                       any_req_s;
    logic                       beat_s;
    logic                       last_beat_s;
    logic [NUM_PORTS-1:0]       req_s;
    logic [NUM_PORTS*CNT_W-1:0] pkt_cnt_r;

    assign req_s      = s_tvalid & port_en;
    assign next_ptr_s = (grant_id_r == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_id_r + IDX_W'(1);

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr_arbiter (
        .req      (req_s),
        .rr_ptr   (rr_ptr_r),
        .arb_mode (arb_mode),
        .winner   (winner_s),
        .any_req  (any_req_s)
    );

    // Next-state decode: grant on any request, release on the tlast beat.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = any_req_s   ? XFER : IDLE;
            XFER:    next_state_s = last_beat_s ? IDLE : XFER;
            default: next_state_s = IDLE;
        endcase
    end

    // Route the granted port straight through; ready only goes back to it.
    always_comb begin
        s_tready    = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        beat_s      = 1'b0;
        last_beat_s = 1'b0;
        m_tdata     = s_tdata[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep     = s_tkeep[int'(grant_id_r)*KEEP_W +: KEEP_W];
        if (state_r == XFER) begin
            s_tready[grant_id_r] = m_tready;
            m_tvalid             = s_tvalid[grant_id_r];
            m_tlast              = s_tlast[grant_id_r];
            beat_s               = s_tvalid[grant_id_r] & m_tready;
            last_beat_s          = beat_s & s_tlast[grant_id_r];
        end else begin
            s_tready = '0;
            m_tvalid = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Grant bookkeeping; the mode is latched at grant so it cannot alter a packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id_r    <= '0;
            grant_valid_r <= 1'b0;
            rr_ptr_r      <= '0;
            mode_r        <= ARB_RR;
        end else if (state_r == IDLE && any_req_s) begin
            grant_id_r    <= winner_s;
            grant_valid_r <= 1'b1;
            mode_r        <= arb_mode;
        end else if (last_beat_s) begin
            grant_valid_r <= 1'b0;
            rr_ptr_r      <= (mode_r == ARB_RR) ? next_ptr_s : rr_ptr_r;
        end else begin
            grant_valid_r <= grant_valid_r;
        end
    end

    // Per-port completed-packet counters; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r <= '0;
        end else if (cnt_clr) begin
            pkt_cnt_r <= '0;
        end else if (last_beat_s) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_id_r == IDX_W'(i)) begin
                    pkt_cnt_r[i*CNT_W +: CNT_W] <= sat_inc(pkt_cnt_r[i*CNT_W +: CNT_W]);
                end
            end
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign grant_id    = grant_id_r;
    assign grant_valid = grant_valid_r;
    assign pkt_cnt     = pkt_cnt_r;

endmodule
